// File: rtl/charlieplex_pwm_scanner.sv
// rtl/charlieplex_pwm_scanner.sv - double-buffered PWM pixel scanner feeding a charlieplexer
// Optional: define CHARLIEPLEX_SKIP_DARK_EN to give level-0 pixels a single-cycle slot.
module charlieplex_pwm_scanner #(
  parameter int PIXELCOUNT = 12,
  parameter int BRIGHTBITS = 4,
  parameter int DEADCYCLES = 2,
  localparam int IDXBITS = $clog2(PIXELCOUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  wr_en,
  input  logic [IDXBITS-1:0]    wr_addr,
  input  logic [BRIGHTBITS-1:0] wr_data,
  input  logic                  commit,
  output logic                  commit_pending,
  output logic [IDXBITS-1:0]    led_index,
  output logic                  led_enable,
  output logic                  frame_start
);

  localparam int ONCYCLES = 2**BRIGHTBITS - 1;
  localparam int CNTBITS  = ($clog2(DEADCYCLES + 1) > BRIGHTBITS) ? $clog2(DEADCYCLES + 1) : BRIGHTBITS;
  localparam logic [CNTBITS-1:0] ON_LAST   = CNTBITS'(ONCYCLES - 1);
  localparam logic [CNTBITS-1:0] DEAD_LAST = CNTBITS'((DEADCYCLES > 0) ? DEADCYCLES - 1 : 0);
  localparam logic [IDXBITS-1:0] IDX_LAST  = IDXBITS'(PIXELCOUNT - 1);
  localparam logic [IDXBITS:0]   PIX_LIMIT = (IDXBITS + 1)'(PIXELCOUNT);

  typedef enum logic {S_ON, S_DEAD} state_t;

  state_t                state, state_n;
  logic [IDXBITS-1:0]    idx, idx_n;
  logic [CNTBITS-1:0]    cnt, cnt_n;
  logic                  started;
  logic                  sel, sel_n;
  logic                  slot_end, wrap, swap, wr_ok, cur_dark;
  logic [BRIGHTBITS-1:0] level_n;
  logic [BRIGHTBITS-1:0] buf_a [PIXELCOUNT];
  logic [BRIGHTBITS-1:0] buf_b [PIXELCOUNT];

  // sel=0: buf_a is front, buf_b is back; a swap only flips sel.
  assign wr_ok = wr_en && ({1'b0, wr_addr} < PIX_LIMIT);
  assign swap  = wrap && (commit_pending || commit);
  assign sel_n = sel ^ swap;

`ifdef CHARLIEPLEX_SKIP_DARK_EN
  assign cur_dark = ((sel ? buf_b[idx] : buf_a[idx]) == '0);
`else
  assign cur_dark = 1'b0;
`endif

  // The first edge after reset holds pixel 0 / cnt 0 so its first ON cycle reaches the outputs.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    cnt_n    = cnt;
    slot_end = 1'b0;
    wrap     = 1'b0;
    if (started) begin
      if (state == S_ON) begin
        if (cnt == ON_LAST || cur_dark) begin
          if (DEADCYCLES == 0 || cur_dark) begin
            slot_end = 1'b1;
          end else begin
            state_n = S_DEAD;
            cnt_n   = '0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end else begin
        if (cnt == DEAD_LAST) slot_end = 1'b1;
        else                  cnt_n = cnt + 1'b1;
      end
      if (slot_end) begin
        state_n = S_ON;
        cnt_n   = '0;
        wrap    = (idx == IDX_LAST);
        idx_n   = wrap ? '0 : idx + 1'b1;
      end
    end
  end

  // A write on the swap edge targets the buffer that becomes front, so forward it.
  always_comb begin
    level_n = sel_n ? buf_b[idx_n] : buf_a[idx_n];
    if (swap && wr_ok && wr_addr == idx_n) level_n = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIXELCOUNT; i++) begin
        buf_a[i] <= '0;
        buf_b[i] <= '0;
      end
      state          <= S_ON;
      idx            <= '0;
      cnt            <= '0;
      started        <= 1'b0;
      sel            <= 1'b0;
      commit_pending <= 1'b0;
      led_index      <= '0;
      led_enable     <= 1'b0;
      frame_start    <= 1'b0;
    end else begin
      started        <= 1'b1;
      state          <= state_n;
      idx            <= idx_n;
      cnt            <= cnt_n;
      sel            <= sel_n;
      commit_pending <= swap ? 1'b0 : (commit_pending || commit);
      if (wr_ok) begin
        if (sel) buf_a[wr_addr] <= wr_data;
        else     buf_b[wr_addr] <= wr_data;
      end
      led_index   <= idx_n;
      led_enable  <= enable && (state_n == S_ON) && (cnt_n < CNTBITS'(level_n));
      frame_start <= (state_n == S_ON) && (idx_n == '0) && (cnt_n == '0);
    end
  end

endmodule

// File: tb/tb_charlieplex_pwm_scanner.sv
// tb/tb_charlieplex_pwm_scanner.sv - self-checking bench for charlieplex_pwm_scanner
module tb_charlieplex_pwm_scanner;

  localparam int PIX  = 12;
  localparam int SLOT = 17;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       commit = 1'b0;
  logic       commit_pending;
  logic [3:0] led_index;
  logic       led_enable;
  logic       frame_start;

  charlieplex_pwm_scanner #(.PIXELCOUNT(12), .BRIGHTBITS(4), .DEADCYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .commit(commit), .commit_pending(commit_pending),
    .led_index(led_index), .led_enable(led_enable), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] idx;
    logic       en;
    logic       fs;
    logic       cp;
  } exp_t;

  typedef struct {
    int ncyc;
    bit en;
    bit we;
    int addr;
    int data;
    bit cm;
    int exp_on;
    int exp_fs;
  } step_t;

  exp_t       sb[$];
  int         n_assert = 0;
  int         n_fail = 0;
  int         on_cnt, fs_cnt;

  int         m_pix, m_off;
  bit         m_started, m_pend;
  logic [3:0] m_front [PIX];
  logic [3:0] m_back  [PIX];

  task automatic check(input string name, input int act, input int req);
    n_assert++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < PIX; i++) begin
      m_front[i] = '0;
      m_back[i]  = '0;
    end
    m_pix = 0; m_off = 0; m_started = 0; m_pend = 0;
  endtask

  // Position-in-frame reference: each pixel owns SLOT cycles, lit for its first `level` cycles.
  task automatic model_step();
    exp_t       e;
    bit         wrap;
    logic [3:0] t;
    wrap = 0;
    if (!rst_n) begin
      model_reset();
      e = '0;
    end else begin
      if (!m_started) begin
        m_started = 1; m_pix = 0; m_off = 0;
      end else begin
        m_off++;
        if (m_off == SLOT) begin
          m_off = 0;
          wrap  = (m_pix == PIX - 1);
          m_pix = wrap ? 0 : m_pix + 1;
        end
      end
      if (wr_en && wr_addr < PIX) m_back[wr_addr] = wr_data;
      if (wrap && (m_pend || commit)) begin
        for (int i = 0; i < PIX; i++) begin
          t = m_front[i]; m_front[i] = m_back[i]; m_back[i] = t;
        end
        m_pend = 0;
      end else if (commit) begin
        m_pend = 1;
      end
      e.idx = 4'(m_pix);
      e.en  = enable && (m_off < int'(m_front[m_pix]));
      e.fs  = (m_pix == 0) && (m_off == 0);
      e.cp  = m_pend;
    end
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e, a;
    model_step();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    a = {led_index, led_enable, frame_start, commit_pending};
    n_assert++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL cycle_out: got idx=%0d en=%b fs=%b cp=%b, expected idx=%0d en=%b fs=%b cp=%b at %0t",
               a.idx, a.en, a.fs, a.cp, e.idx, e.en, e.fs, e.cp, $time);
    end
    on_cnt += int'(led_enable);
    fs_cnt += int'(frame_start);
  endtask

  step_t tbl [10];

  initial begin
    tbl[0] = '{204, 1, 0, 0,  0, 0,  0, 1};  // idle, all dark
    tbl[1] = '{204, 1, 1, 3,  5, 1,  5, 1};  // write+commit on the swap edge
    tbl[2] = '{204, 1, 1, 0, 15, 0,  5, 1};  // back-buffer write, no commit
    tbl[3] = '{ 10, 1, 0, 0,  0, 0,  0, 1};
    tbl[4] = '{194, 1, 0, 0,  0, 1,  5, 0};  // commit mid-frame
    tbl[5] = '{204, 1, 0, 0,  0, 0, 15, 1};  // pixel 0 full after swap
    tbl[6] = '{204, 0, 0, 0,  0, 0,  0, 1};  // display disabled
    tbl[7] = '{  7, 1, 0, 0,  0, 0,  7, 1};
    tbl[8] = '{197, 0, 0, 0,  0, 0,  0, 0};  // enable drops mid-slot
    tbl[9] = '{204, 1, 0, 0,  0, 0, 15, 1};

    model_reset();
    #2;
    check("reset_idx", int'(led_index), 0);
    check("reset_en", int'(led_enable), 0);
    check("reset_fs", int'(frame_start), 0);
    check("reset_cp", int'(commit_pending), 0);
    #5 rst_n = 1'b1;

    for (int s = 0; s < 10; s++) begin
      enable  = tbl[s].en;
      wr_en   = tbl[s].we;
      wr_addr = 4'(tbl[s].addr);
      wr_data = 4'(tbl[s].data);
      commit  = tbl[s].cm;
      on_cnt = 0; fs_cnt = 0;
      for (int c = 0; c < tbl[s].ncyc; c++) begin
        tick();
        wr_en = 1'b0; commit = 1'b0;
      end
      check($sformatf("step%0d_on", s), on_cnt, tbl[s].exp_on);
      check($sformatf("step%0d_fs", s), fs_cnt, tbl[s].exp_fs);
    end

    // Pending flag lifetime; a repeated commit adds nothing.
    enable = 1'b1;
    repeat (5) tick();
    commit = 1'b1; tick(); commit = 1'b0;
    check("cp_rise", int'(commit_pending), 1);
    commit = 1'b1; tick(); commit = 1'b0;
    repeat (197) tick();
    check("cp_hold", int'(commit_pending), 1);
    on_cnt = 0;
    tick();
    check("cp_drop", int'(commit_pending), 0);
    check("fs_swap", int'(frame_start), 1);
    repeat (203) tick();
    check("swap_prev_frame_on", on_cnt, 5);

    // Asynchronous reset mid-frame with a commit pending.
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 4'd9; commit = 1'b1;
    tick();
    wr_en = 1'b0; commit = 1'b0;
    repeat (49) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_idx", int'(led_index), 0);
    check("midrst_en", int'(led_enable), 0);
    check("midrst_cp", int'(commit_pending), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    on_cnt = 0; fs_cnt = 0;
    repeat (204) tick();
    check("postrst_on", on_cnt, 0);
    check("postrst_fs", fs_cnt, 1);

    // Out-of-range address is dropped even when committed.
    wr_en = 1'b1; wr_addr = 4'd13; wr_data = 4'd15; commit = 1'b1;
    on_cnt = 0;
    tick();
    wr_en = 1'b0; commit = 1'b0;
    repeat (203) tick();
    check("oob_write_on", on_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/charlieplex_pwm_scanner.md
Name: charlieplex_pwm_scanner

Overview:
- Upstream stage for the charlieplexer.
- Holds a double-buffered framebuffer of per-pixel brightness levels and scans the pixels in sequence.
- Generates per-pixel PWM with dead-time blanking between pixels.
- Drives the charlieplexer's LED-index and enable inputs directly; the combinational charlieplexer sits downstream and maps index/enable to pin drive.

Parameters:
- PIXELCOUNT, 12, number of LEDs scanned; must be >= 2.
- BRIGHTBITS, 4, bits per brightness level; ON phase is 2^BRIGHTBITS-1 cycles.
- DEADCYCLES, 2, blanking cycles after each pixel's ON phase; 0 is legal (no DEAD phase).
- Derived localparam IDXBITS = $clog2(PIXELCOUNT).

Ports:
- clk, input, 1, single clock.
- rst_n, input, 1, asynchronous active-low reset.
- enable, input, 1, global display enable; gates led_enable only, scanning continues.
- wr_en, input, 1, write strobe into back buffer.
- wr_addr, input, IDXBITS, pixel to write; values >= PIXELCOUNT are ignored.
- wr_data, input, BRIGHTBITS, brightness level (0 = off, 2^BRIGHTBITS-1 = full).
- commit, input, 1, request back/front buffer swap at the next frame boundary.
- commit_pending, output, 1, high from the cycle after commit until the swap occurs.
- led_index, output, IDXBITS, pixel index to the charlieplexer's in; zero-extend at integration.
- led_enable, output, 1, to the charlieplexer's enable.
- frame_start, output, 1, one-cycle pulse on the first ON cycle of pixel 0.

Behaviour:
- Reset (async, rst_n low):
  - Both buffers cleared to 0; pixel index 0; state ON; PWM counter 0.
  - led_index 0, led_enable 0, frame_start 0, commit_pending 0.
- All outputs are registered, updated on the posedge of clk.
- State machine: ON -> DEAD -> ON (next pixel).
- ON phase:
  - Lasts 2^BRIGHTBITS-1 cycles; counter cnt runs 0..2^BRIGHTBITS-2.
  - led_enable = enable & (cnt < front[idx]).
  - Level L therefore gives exactly L enabled cycles, contiguous at the start of the slot.
- DEAD phase:
  - Lasts DEADCYCLES cycles with led_enable 0.
  - led_index holds the current pixel during DEAD.
  - With DEADCYCLES = 0, ON goes straight to the next pixel's ON.
- Pixel advance: idx increments at the end of each slot; PIXELCOUNT-1 wraps to 0.
- Frame:
  - Frame length = PIXELCOUNT*(2^BRIGHTBITS-1+DEADCYCLES) cycles.
  - frame_start pulses on every pixel-0 first ON cycle, including the first cycle after reset release.
- Writes:
  - wr_en writes wr_data to back[wr_addr] on the clock edge.
  - The front buffer is never written directly.
- Commit:
  - commit sets the pending flag; commit_pending reads high the next cycle.
  - A commit while already pending has no additional effect.
  - The swap happens at the edge where idx wraps to 0.
  - The new front buffer is used from pixel 0's first ON cycle; commit_pending drops the same cycle.
- Swap semantics:
  - The swap exchanges buffer roles; it does not copy.
  - The new back buffer holds the previously displayed frame.
- Simultaneous events:
  - Write and swap in the same cycle: the write lands in the pre-swap back buffer, so it becomes visible.
  - commit asserted on the swap edge itself: it is taken by that swap and leaves no residual pending.
- enable low:
  - led_enable is 0 next cycle.
  - idx, cnt and frame timing are unaffected.
- Reset mid-frame: immediately returns to the reset state and discards any pending commit.

Optional Feature:
- Macro: CHARLIEPLEX_SKIP_DARK_EN.
- Defined:
  - A pixel whose front level is 0 gets a 1-cycle slot: one ON cycle with led_enable 0, no DEAD phase, then advance.
  - Frame length shrinks accordingly; the wrap, swap and frame_start rules are unchanged.
  - An all-dark frame lasts PIXELCOUNT cycles.
- Undefined: every pixel uses the full slot regardless of level.

Test Plan:
- Reset then idle (defaults, all levels 0) -> led_enable stays 0; frame_start pulses every 12*(15+2)=204 cycles; led_index steps 0..11 every 17 cycles.
- Write level 5 to pixel 3, commit -> commit_pending high until the next wrap; then in pixel 3's slot led_enable is high exactly 5 cycles followed by 12 low, with led_index=3.
- Write level 15 to pixel 0 without commit -> no change in output; after commit and wrap -> 15 consecutive enabled cycles at index 0 while 2 dead cycles are low.
- Assert enable=0 mid-slot of a lit pixel -> led_enable 0 next cycle; frame_start period remains 204.
- Assert rst_n low mid-frame with commit pending -> outputs 0 immediately; commit_pending 0; first frame after release shows all pixels dark.
- With CHARLIEPLEX_SKIP_DARK_EN defined and only pixel 7 = 15 -> frame length 11*1+17=28 cycles; pixel 7 enabled 15 cycles.
